// File: rtl/lap_stopwatch_pkg.sv
// Shared types and BCD helper for the lap stopwatch.
// Defining HOURS_EN adds hour digits to the time record, which widens lap entries to 24 bits.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
`ifdef HOURS_EN
        bcd_t hr_tens;
        bcd_t hr_ones;
`endif
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } time_bcd_t;

    typedef struct packed {
        logic carry;
        bcd_t digit;
    } bcd_step_t;

    localparam int LAP_W = $bits(time_bcd_t);

    // Advance one BCD digit. When the digit already sits at 'last', it wraps to 0 and carries.
    function automatic bcd_step_t bcd_inc(input bcd_t d, input bcd_t last);
        bcd_step_t r;
        if (d >= last) begin
            r.carry = 1'b1;
            r.digit = '0;
        end else begin
            r.carry = 1'b0;
            r.digit = d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_stopwatch_lap_fifo.sv
// Show-ahead FIFO for lap entries. The head is presented combinationally and reads as zero when the FIFO is empty.
// A flush empties the FIFO and takes precedence over push and pop in the same cycle.
module lap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A push into a full FIFO is accepted only if a pop frees the slot in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch that counts MM:SS in BCD, with start/stop/clear/lap command decode and a lap FIFO.
// Defining HOURS_EN adds HH digits and moves the wrap point to 23:59:59.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         cmd_start,
    input  logic                         cmd_stop,
    input  logic                         cmd_clear,
    input  logic                         cmd_lap,
    input  logic                         lap_rd,
    output logic                         running,
`ifdef HOURS_EN
    output logic [3:0]                   hr_tens,
    output logic [3:0]                   hr_ones,
`endif
    output logic [3:0]                   min_tens,
    output logic [3:0]                   min_ones,
    output logic [3:0]                   sec_tens,
    output logic [3:0]                   sec_ones,
    output logic                         lap_valid,
    output logic [LAP_W-1:0]             lap_time,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_ovf,
    output logic                         wrapped
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          running_q, running_d;
    logic [PW-1:0] presc_q, presc_d;
    time_bcd_t     time_q, time_d, time_inc;
    logic          wrapped_q, wrapped_d;
    logic          lap_ovf_q, lap_ovf_d;

    logic do_clear, do_push, do_pop, counting, tick;
    logic min_carry, wrap_carry;
    logic fifo_full, fifo_empty;
    bcd_step_t st0, st1, st2, st3;
`ifdef HOURS_EN
    bcd_step_t st4;
`endif

    // When enable is low, every command and lap_rd is ignored. Clear also blocks push and pop.
    assign do_clear = enable & cmd_clear;
    assign do_push  = enable & cmd_lap & ~cmd_clear;
    assign do_pop   = enable & lap_rd & ~cmd_clear;
    assign counting = running_q & enable;
    assign tick     = counting & (presc_q == PRESC_LAST);

    always_comb begin
        time_inc   = time_q;
        min_carry  = 1'b0;
        wrap_carry = 1'b0;
        st0 = bcd_inc(time_q.sec_ones, 4'd9);
        st1 = bcd_inc(time_q.sec_tens, 4'd5);
        st2 = bcd_inc(time_q.min_ones, 4'd9);
        st3 = bcd_inc(time_q.min_tens, 4'd5);
        time_inc.sec_ones = st0.digit;
        if (st0.carry) begin
            time_inc.sec_tens = st1.digit;
            if (st1.carry) begin
                time_inc.min_ones = st2.digit;
                if (st2.carry) begin
                    time_inc.min_tens = st3.digit;
                    min_carry         = st3.carry;
                end
            end
        end
`ifdef HOURS_EN
        st4 = bcd_inc(time_q.hr_ones, 4'd9);
        // Hours roll over from 23 straight to 00 rather than running up to 29.
        if (min_carry) begin
            if (time_q.hr_tens == 4'd2 && time_q.hr_ones == 4'd3) begin
                time_inc.hr_tens = '0;
                time_inc.hr_ones = '0;
                wrap_carry       = 1'b1;
            end else begin
                time_inc.hr_ones = st4.digit;
                if (st4.carry) time_inc.hr_tens = time_q.hr_tens + 4'd1;
            end
        end
`else
        wrap_carry = min_carry;
`endif
    end

    always_comb begin
        running_d = running_q;
        presc_d   = presc_q;
        time_d    = time_q;
        wrapped_d = wrapped_q;
        lap_ovf_d = lap_ovf_q;
        if (enable) begin
            if (cmd_stop)       running_d = 1'b0;
            else if (cmd_start) running_d = 1'b1;
        end
        if (counting) presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
            time_d = time_inc;
            if (wrap_carry) wrapped_d = 1'b1;
        end
        if (do_push && fifo_full && !do_pop) lap_ovf_d = 1'b1;
        // Clear wins over the other updates but leaves running to the stop/start decode.
        if (do_clear) begin
            presc_d   = '0;
            time_d    = '0;
            wrapped_d = 1'b0;
            lap_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            presc_q   <= '0;
            time_q    <= '0;
            wrapped_q <= 1'b0;
            lap_ovf_q <= 1'b0;
        end else begin
            running_q <= running_d;
            presc_q   <= presc_d;
            time_q    <= time_d;
            wrapped_q <= wrapped_d;
            lap_ovf_q <= lap_ovf_d;
        end
    end

    lap_fifo #(
        .DEPTH (LAP_DEPTH),
        .WIDTH (LAP_W)
    ) u_lap_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (do_clear),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .data_i  (time_q),
        .head_o  (lap_time),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (lap_count)
    );

    assign lap_valid = ~fifo_empty;
    assign running   = running_q;
`ifdef HOURS_EN
    assign hr_tens   = time_q.hr_tens;
    assign hr_ones   = time_q.hr_ones;
`endif
    assign min_tens  = time_q.min_tens;
    assign min_ones  = time_q.min_ones;
    assign sec_tens  = time_q.sec_tens;
    assign sec_ones  = time_q.sec_ones;
    assign lap_ovf   = lap_ovf_q;
    assign wrapped   = wrapped_q;

endmodule
